// File: rtl/sevseg_scan_driver_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sevseg_scan_driver_if - digit patterns in, scanned segment/digit pins out |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sevseg_scan_driver_if;
  logic       enable;
  logic [7:0] seg_1_in;
  logic [7:0] seg_2_in;
  logic [7:0] seg_3_in;
  logic [7:0] seg_4_in;
  logic [7:0] seg_out;
  logic [3:0] dig_out;
  logic       frame_tick;

  modport master (
    output enable, seg_1_in, seg_2_in, seg_3_in, seg_4_in,
    input  seg_out, dig_out, frame_tick
  );

  modport slave (
    input  enable, seg_1_in, seg_2_in, seg_3_in, seg_4_in,
    output seg_out, dig_out, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/sevseg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sevseg_scan_driver - 4-digit scanned seven-segment driver, frame snapshot |
// | Rev 1.0   optional blanking phase: SEVSEG_DEADTIME_EN                    |
// +--------------------------------------------------------------------------+
module sevseg_scan_driver #(
  parameter int DIGIT_CYCLES = 12500,
  parameter int DEAD_CYCLES  = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  sevseg_scan_driver_if.slave  bus
);

  localparam int              CNT_W    = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [7:0]      SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0]      DIG_OFF  = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;
`ifdef SEVSEG_DEADTIME_EN
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
`endif

  generate
    if (DIGIT_CYCLES < 4 || DEAD_CYCLES >= DIGIT_CYCLES || DEAD_CYCLES < 0) begin : g_param_check
      $error("sevseg_scan_driver: illegal DIGIT_CYCLES/DEAD_CYCLES combination");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       shadow_q [4];
  logic [7:0]       shadow_d [4];
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       dig_q, dig_d;
  logic             frame_tick_q, frame_tick_d;

  logic             frame_start;
  logic             show;
  logic [7:0]       lit_seg;
  logic [3:0]       lit_dig;

  // Slot timing and frame snapshot run regardless of enable.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    frame_start  = (idx_q == 2'd3) && (cnt_q == CNT_LAST);
    frame_tick_d = frame_start;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (frame_start) begin
      shadow_d[0] = bus.seg_1_in;
      shadow_d[1] = bus.seg_2_in;
      shadow_d[2] = bus.seg_3_in;
      shadow_d[3] = bus.seg_4_in;
    end
  end

  // Output decode in active-high logic, polarity applied at the pins.
  always_comb begin
    show    = 1'b1;
`ifdef SEVSEG_DEADTIME_EN
    show    = (cnt_q >= CNT_DEAD);
`endif
    lit_seg = 8'h00;
    lit_dig = 4'h0;
    if (bus.enable && show) begin
      lit_dig = 4'b0001 << idx_q;
      lit_seg = shadow_q[idx_q];
    end
    seg_d = (ACTIVE_LOW != 0) ? ~lit_seg : lit_seg;
    dig_d = (ACTIVE_LOW != 0) ? ~lit_dig : lit_dig;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= 8'h00;
      seg_q        <= SEG_OFF;
      dig_q        <= DIG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dig_out    = dig_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sevseg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sevseg_scan_driver - directed bench, DIGIT_CYCLES=8 DEAD_CYCLES=2      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sevseg_scan_driver;

`ifdef SEVSEG_DEADTIME_EN
  localparam int TB_DEAD = 2;
`else
  localparam int TB_DEAD = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  sevseg_scan_driver_if bus ();

  sevseg_scan_driver #(
    .DIGIT_CYCLES (8),
    .DEAD_CYCLES  (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Pin-level patterns: frame 1 shows 3F/06/5B/4F, later frames have digit 1 = 7F.
  logic [7:0] seg_f1 [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
  logic [7:0] seg_f2 [4] = '{8'hC0, 8'h80, 8'hA4, 8'hB0};
  logic [3:0] dig_on [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // p = cycle index since reset release of the state the output reflects.
  task automatic check_pos(input int n, input int p, input bit en, input bit tick_exp);
    int         cnt, idx, frame;
    logic [7:0] seg_e;
    logic [3:0] dig_e;
    cnt   = p % 8;
    idx   = (p / 8) % 4;
    frame = p / 32;
    seg_e = 8'hFF;
    dig_e = 4'hF;
    if (en && cnt >= TB_DEAD) begin
      dig_e = dig_on[idx];
      if (frame == 1)      seg_e = seg_f1[idx];
      else if (frame >= 2) seg_e = seg_f2[idx];
    end
    check($sformatf("seg n=%0d", n), bus.seg_out, seg_e);
    check($sformatf("dig n=%0d", n), {4'h0, bus.dig_out}, {4'h0, dig_e});
    check($sformatf("tick n=%0d", n), {7'h0, bus.frame_tick}, {7'h0, tick_exp});
  endtask

  always @(negedge clk) begin
    tests++;
    assert ($countones(~bus.dig_out) <= 1) else begin
      fails++;
      $error("FAIL onehot: observed dig_out %h required at most one active", bus.dig_out);
    end
  end

  initial begin
    bit en;
    bus.enable   = 1'b1;
    bus.seg_1_in = 8'h00;
    bus.seg_2_in = 8'h00;
    bus.seg_3_in = 8'h00;
    bus.seg_4_in = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset seg", bus.seg_out, 8'hFF);
    check("reset dig", {4'h0, bus.dig_out}, 8'h0F);
    check("reset tick", {7'h0, bus.frame_tick}, 8'h00);

    bus.seg_1_in = 8'h3F;
    bus.seg_2_in = 8'h06;
    bus.seg_3_in = 8'h5B;
    bus.seg_4_in = 8'h4F;
    rst = 1'b0;

    for (int n = 1; n <= 150; n++) begin
      en = !(n >= 100 && n <= 104);
      bus.enable = en;
      if (n == 35) bus.seg_2_in = 8'h7F;
      @(posedge clk);
      #1;
      check_pos(n, n - 1, en, (n % 32) == 0);
    end

    // Mid-slot reset at idx=2: outputs must drop before any clock edge.
    bus.enable = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async seg", bus.seg_out, 8'hFF);
    check("async dig", {4'h0, bus.dig_out}, 8'h0F);
    check("async tick", {7'h0, bus.frame_tick}, 8'h00);
    @(posedge clk);
    #1;
    check("rst hold dig", {4'h0, bus.dig_out}, 8'h0F);
    rst = 1'b0;

    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      check_pos(200 + n, n - 1, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sevseg_scan_driver.md
# sevseg_scan_driver

Board-side consumer of the four 8-bit seven-segment PIO exports of the Nios II system. Snapshots all four digit patterns once per frame and time-multiplexes them onto one shared segment bus plus four digit enables, for a scanned 4-digit common-anode display module. Sits in the top-level wrapper between the Qsys system and the FPGA pins.

## Interface

- DIGIT_CYCLES, 12500, clock cycles per digit slot (250 us at 50 MHz, 1 kHz frame); must be ≥ 4
- DEAD_CYCLES, 500, blanking cycles at the start of each slot; must be < DIGIT_CYCLES
- ACTIVE_LOW, 1, 1 = segment and digit outputs active-low, 0 = active-high

- clk_clk  input  1  system clock (50 MHz)
- reset_reset  input  1  asynchronous, active-high reset
- enable  input  1  1 = scan and display; 0 = blank all outputs, scan timing keeps running
- seg_1_in  input  8  digit 0 pattern, bits [6:0] = segments a..g, bit 7 = decimal point, 1 = lit
- seg_2_in  input  8  digit 1 pattern, same format
- seg_3_in  input  8  digit 2 pattern
- seg_4_in  input  8  digit 3 pattern
- seg_out  output  8  shared segment bus, polarity per ACTIVE_LOW
- dig_out  output  4  one-hot digit enables, bit n = digit n, polarity per ACTIVE_LOW
- frame_tick  output  1  one-cycle pulse when a new frame snapshot is taken

## Operation

- Slot counter cnt counts 0..DIGIT_CYCLES-1, then wraps to 0 and advances digit index idx 0→1→2→3→0.
- Frame start = (idx==3 and cnt==DIGIT_CYCLES-1), i.e. the cycle before idx wraps to 0: all four seg_n_in are captured into shadow registers; frame_tick asserts for the following cycle.
- Inputs are only sampled at frame start; changes mid-frame never appear until the next frame (no tearing).
- Per slot, two phases: BLANK while cnt < DEAD_CYCLES (all digits off, all segments off); SHOW while cnt ≥ DEAD_CYCLES (dig_out enables digit idx only, seg_out = shadow[idx]).
- Logical "lit"/"on" is inverted at the pins when ACTIVE_LOW=1; all internal logic is active-high.
- enable=0: seg_out and dig_out forced to off state on the next cycle; cnt, idx, snapshots and frame_tick continue unaffected. Re-enabling resumes at the current phase.
- Never more than one digit enable active in any cycle, including across slot boundaries and reset.

## Timing

- All outputs registered; output reflects cnt/idx/enable state of the previous cycle (1-cycle latency).
- Reset values: seg_out = all off (8'hFF if ACTIVE_LOW else 8'h00), dig_out = all off (4'hF / 4'h0), frame_tick = 0, cnt = 0, idx = 0, shadow = 0.
- First snapshot after reset is taken at frame start; until then SHOW phases display blank (shadow=0).
- Reset asserted mid-slot: outputs go to off immediately (asynchronous); after release, counting restarts at cnt=0, idx=0.
- Frame period = 4 × DIGIT_CYCLES cycles; lit time per digit per frame = DIGIT_CYCLES − DEAD_CYCLES.
- cnt width = clog2(DIGIT_CYCLES); no counter may overflow for any legal parameter value.

## Configuration

- SEVSEG_DEADTIME_EN defined: BLANK phase implemented as above with DEAD_CYCLES.
- SEVSEG_DEADTIME_EN undefined: DEAD_CYCLES ignored, no BLANK phase; digit idx shows for the full slot, and digit switchover occurs in a single cycle (old enable off and new enable on in the same output update).

## Test plan

- DIGIT_CYCLES=8, DEAD_CYCLES=2, ACTIVE_LOW=1; during reset and first cycle after release -> seg_out=8'hFF, dig_out=4'hF, frame_tick=0.
- Inputs 8'h3F/8'h06/8'h5B/8'h4F held across one frame start -> next frame: per slot 2 cycles dig_out=4'hF, then 6 cycles dig_out=4'hE,D,B,7 in turn with seg_out=8'hC0,F9,A4,B0; frame_tick one pulse per 32 cycles.
- Change seg_2_in to 8'h7F while idx=0 -> digit 1 still shows 8'hF9 this frame, 8'h80 next frame.
- Drop enable for 5 cycles inside a SHOW phase -> outputs off for exactly those 5 cycles (delayed 1), frame_tick period unchanged at 32 cycles.
- Assert reset_reset mid-slot at idx=2 -> outputs off asynchronously; after release, first SHOW is idx=0 at cycle 3 after release; assertion check: popcount of active dig_out ≤ 1 every cycle.
- Compile without SEVSEG_DEADTIME_EN -> each digit active all 8 cycles of its slot, no all-off cycle between digits.
